alu_rr_arbiter: RTL and testbench

Shares one ALU2 instance among NREQ independent requesters using a round-robin policy. Each requester submits an (A, B, op) command over a valid/ready handshake. The block latches the command, sequences ALU2's data_enable/control_enable, captures Result on result_enable, and returns the result to the granted requester over a per-requester response handshake. It sits between the requester clients and ALU2, and it is the only driver of ALU2's input ports.

---
 rtl/alu_rr_arbiter_pkg.sv | 24 ++
 rtl/alu_rr_arbiter_rr_pick.sv | 39 +++
 rtl/alu_rr_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rr_arbiter_pkg.sv
// Shared state encoding, opcode constants and width helpers for the ALU2 round-robin arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam int         DEF_DW  = 8;
  localparam int         DEF_OPW = 4;
  localparam int         DEF_RW  = 16;

  // Ceiling log2, floored at 1 so index fields always have at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request strictly after last_grant, with wrap.
module rr_pick
  import alu_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_grant_i,
  output logic          any_o,
  output logic [GW-1:0] grant_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;

  // Positions above last_grant in the doubled vector visit every requester once,
  // starting at last_grant+1 and wrapping through the upper copy.
  assign dbl = {req_i, req_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2 * N; gi++) begin : g_mask
      assign mask[gi] = (gi > int'(last_grant_i));
    end
  endgenerate

  assign masked = dbl & mask;
  assign any_o  = |req_i;

  always_comb begin
    grant_o = '0;
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (masked[j]) grant_o = GW'(j % N);
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU2 among NREQ requesters with per-requester response handshake.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int  NREQ    = 4,
  parameter int  DW      = DEF_DW,
  parameter int  OPW     = DEF_OPW,
  parameter int  RW      = DEF_RW,
  parameter int  TIMEOUT = 4,
  localparam int GW      = clog2(NREQ)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [RW-1:0]       rsp_data,
  output logic                rsp_err,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [OPW-1:0]      alu_control,
  output logic                alu_data_enable,
  output logic                alu_control_enable,
  input  logic [RW-1:0]       alu_result,
  input  logic                alu_result_enable,
  output logic                busy,
  output logic [GW-1:0]       grant_id
);

  localparam int            CW       = clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e      state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [RW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [OPW-1:0]  alu_ctl_q, alu_ctl_d;
  logic            alu_de_q, alu_de_d;
  logic            alu_ce_q, alu_ce_d;
  logic            busy_q;

  logic            pick_any;
  logic [GW-1:0]   pick_id;
  logic [DW-1:0]   pick_a, pick_b;
  logic [OPW-1:0]  pick_op;
  logic            pick_div0;
  logic [NREQ-1:0] grant_oh;

  rr_pick #(
    .N  (NREQ),
    .GW (GW)
  ) u_pick (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .any_o        (pick_any),
    .grant_o      (pick_id)
  );

  assign pick_a    = req_a[int'(pick_id) * DW +: DW];
  assign pick_b    = req_b[int'(pick_id) * DW +: DW];
  assign pick_op   = req_op[int'(pick_id) * OPW +: OPW];
  assign pick_div0 = (pick_op == OPW'(OP_DIV)) && (pick_b == '0);
  assign grant_oh  = NREQ'(1) << grant_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= GW'(NREQ - 1);
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctl_q   <= '0;
      alu_de_q    <= 1'b0;
      alu_ce_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctl_q   <= alu_ctl_d;
      alu_de_q    <= alu_de_d;
      alu_ce_q    <= alu_ce_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = pick_div0 ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (alu_result_enable || (cnt_q == CNT_LAST)) state_d = RESP;
      RESP:    if (rsp_ready[grant_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctl_d   = alu_ctl_q;
    alu_de_d    = 1'b0;
    alu_ce_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Accept is suppressed during reset so no handshake completes in that cycle.
        if (pick_any && !reset) begin
          req_ready[pick_id] = 1'b1;
          grant_d   = pick_id;
          alu_a_d   = pick_a;
          alu_b_d   = pick_b;
          alu_ctl_d = pick_op;
          if (pick_div0) begin
            rsp_valid_d = NREQ'(1) << pick_id;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else begin
            alu_de_d = 1'b1;
            alu_ce_d = 1'b1;
          end
        end
      end
      ISSUE: cnt_d = '0;
      WAIT: begin
        if (alu_result_enable) begin
          rsp_data_d  = alu_result;
          rsp_err_d   = 1'b0;
          rsp_valid_d = grant_oh;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = grant_oh;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          last_d      = grant_q;
        end
      end
      default: ;
    endcase
  end

  assign rsp_valid          = rsp_valid_q & {NREQ{~reset}};
  assign rsp_data           = rsp_data_q;
  assign rsp_err            = rsp_err_q;
  assign alu_a              = alu_a_q;
  assign alu_b              = alu_b_q;
  assign alu_control        = alu_ctl_q;
  assign alu_data_enable    = alu_de_q;
  assign alu_control_enable = alu_ce_q;
  assign busy               = busy_q;
  assign grant_id           = grant_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: stub ALU2 with programmable latency plus a rotational-order reference model.
module tb_alu_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int OPW     = 4;
  localparam int RW      = 16;
  localparam int TIMEOUT = 4;
  localparam int GW      = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*DW-1:0]  req_a, req_b;
  logic [NREQ*OPW-1:0] req_op;
  logic [RW-1:0]       rsp_data;
  logic                rsp_err;
  logic [DW-1:0]       alu_a, alu_b;
  logic [OPW-1:0]      alu_control;
  logic                alu_data_enable, alu_control_enable;
  logic [RW-1:0]       alu_result;
  logic                alu_result_enable;
  logic                busy;
  logic [GW-1:0]       grant_id;

  int n_checks = 0;
  int n_errors = 0;
  int last_g;
  int stub_lat = 1;
  int pend;
  logic [RW-1:0]  stub_res;
  logic [DW-1:0]  cmd_a [NREQ];
  logic [DW-1:0]  cmd_b [NREQ];
  logic [OPW-1:0] cmd_op[NREQ];
  int lat_tab[8] = '{1, 1, 1, 2, 4, 5, 0, 3};

  always #5 clock = ~clock;

  alu_rr_arbiter #(
    .NREQ(NREQ), .DW(DW), .OPW(OPW), .RW(RW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_a              (req_a),
    .req_b              (req_b),
    .req_op             (req_op),
    .req_ready          (req_ready),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_data           (rsp_data),
    .rsp_err            (rsp_err),
    .alu_a              (alu_a),
    .alu_b              (alu_b),
    .alu_control        (alu_control),
    .alu_data_enable    (alu_data_enable),
    .alu_control_enable (alu_control_enable),
    .alu_result         (alu_result),
    .alu_result_enable  (alu_result_enable),
    .busy               (busy),
    .grant_id           (grant_id)
  );

  // Behaviour of the ALU2 being shared: add, sub, mul, div, otherwise xor.
  function automatic logic [RW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [OPW-1:0] op);
    case (op)
      4'h0:    return RW'(a) + RW'(b);
      4'h1:    return RW'(a) - RW'(b);
      4'h2:    return RW'(a) * RW'(b);
      4'h3:    return (b == '0) ? '0 : RW'(a / b);
      default: return RW'(a ^ b);
    endcase
  endfunction

  // Stub ALU2: result_enable fires stub_lat cycles after an issue; 0 means never.
  always @(posedge clock) begin
    if (reset) begin
      pend <= 0;
    end else if (alu_data_enable && alu_control_enable) begin
      pend     <= stub_lat;
      stub_res <= alu_ref(alu_a, alu_b, alu_control);
    end else if (pend > 0) begin
      pend <= pend - 1;
    end
  end
  assign alu_result_enable = (pend == 1);
  assign alu_result        = stub_res;

  // Reference arbitration: walk requesters in rotational order after the last winner.
  function automatic int rr_model(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW]    = cmd_a[i];
      req_b[i*DW +: DW]    = cmd_b[i];
      req_op[i*OPW +: OPW] = cmd_op[i];
    end
  endtask

  task automatic rand_cmds();
    for (int i = 0; i < NREQ; i++) begin
      cmd_a[i]  = DW'($urandom);
      cmd_b[i]  = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      cmd_op[i] = OPW'($urandom_range(0, 4));
    end
    pack();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_alu_control", 32'(alu_control), 0);
    chk("rst_alu_de", 32'(alu_data_enable), 0);
    chk("rst_alu_ce", 32'(alu_control_enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
  endtask

  // One full transaction, starting and ending at a falling edge with the DUT in IDLE.
  task automatic run_txn(input logic [NREQ-1:0] mask, input int lat, input int hold);
    int              w, c, exp_lat;
    logic            div0, err;
    logic [RW-1:0]   data;
    logic [DW-1:0]   ea, eb;
    logic [OPW-1:0]  eop;
    logic [NREQ-1:0] oh;
    w       = rr_model(mask, last_g);
    ea      = cmd_a[w];
    eb      = cmd_b[w];
    eop     = cmd_op[w];
    oh      = NREQ'(1) << w;
    div0    = (eop == 4'h3) && (eb == '0);
    err     = div0 || (lat == 0) || (lat > TIMEOUT);
    data    = err ? '0 : alu_ref(ea, eb, eop);
    exp_lat = div0 ? 1 : 2 + (((lat == 0) || (lat > TIMEOUT)) ? TIMEOUT : lat);
    stub_lat  = lat;
    req_valid = mask;
    rsp_ready = '0;
    #1;
    chk("accept_ready", 32'(req_ready), 32'(oh));
    chk("idle_busy", 32'(busy), 0);
    @(posedge clock);
    c = 0;
    do begin
      @(negedge clock);
      c++;
      if (c == 1) begin
        chk("grant_id", 32'(grant_id), 32'(w));
        chk("busy_after_accept", 32'(busy), 1);
        if (!div0) begin
          chk("issue_alu_a", 32'(alu_a), 32'(ea));
          chk("issue_alu_b", 32'(alu_b), 32'(eb));
          chk("issue_alu_control", 32'(alu_control), 32'(eop));
        end
        // Changing the granted requester's inputs now must not disturb the latched command.
        for (int i = 0; i < NREQ; i++) begin
          cmd_a[i] = DW'($urandom);
          cmd_b[i] = DW'($urandom);
        end
        pack();
      end
      chk("alu_data_enable", 32'(alu_data_enable), 32'(c == 1 && !div0));
      chk("alu_control_enable", 32'(alu_control_enable), 32'(c == 1 && !div0));
      chk("busy_no_ready", 32'(req_ready), 0);
    end while (rsp_valid == '0 && c < 20);
    chk("rsp_latency", 32'(c), 32'(exp_lat));
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_data", 32'(rsp_data), 32'(data));
    chk("rsp_err", 32'(rsp_err), 32'(err));
    if (!div0) chk("alu_a_hold", 32'(alu_a), 32'(ea));
    rsp_ready = ~oh;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'(oh));
      chk("hold_rsp_data", 32'(rsp_data), 32'(data));
      chk("hold_no_ready", 32'(req_ready), 0);
    end
    rsp_ready = oh;
    @(negedge clock);
    chk("done_rsp_valid", 32'(rsp_valid), 0);
    chk("done_busy", 32'(busy), 0);
    rsp_ready = '0;
    last_g    = w;
    $display("txn: mask=%b winner=%0d a=%0h b=%0h op=%0h lat=%0d -> data=%0h err=%0d after %0d cycles",
             mask, w, ea, eb, eop, lat, rsp_data, rsp_err, c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    rsp_ready = '0;
    rand_cmds();
    req_valid = '1;
    repeat (3) @(negedge clock);
    chk("reset_cycle_ready", 32'(req_ready), 0);
    chk_reset_outputs();
    reset     = 1'b0;
    req_valid = '0;
    last_g    = NREQ - 1;

    // Single add from requester 2.
    cmd_a[2] = 8'd5; cmd_b[2] = 8'd3; cmd_op[2] = 4'h0; pack();
    run_txn(4'b0100, 1, 0);

    // All requesters valid: strict rotation.
    for (int t = 0; t < 5; t++) begin
      rand_cmds();
      cmd_op[t % NREQ] = 4'h0;
      pack();
      run_txn(4'b1111, 1, 0);
    end

    // Divide by zero short-circuits, then a legal divide.
    cmd_a[1] = 8'd9; cmd_b[1] = 8'd0; cmd_op[1] = 4'h3; pack();
    run_txn(4'b0010, 1, 0);
    cmd_a[1] = 8'd9; cmd_b[1] = 8'd2; cmd_op[1] = 4'h3; pack();
    run_txn(4'b0010, 1, 0);

    // Timeout boundary: dead ALU, slowest acceptable, one past, then nominal.
    for (int t = 0; t < 4; t++) begin
      rand_cmds();
      cmd_op[3] = 4'h2;
      pack();
      run_txn(4'b1000, (t == 0) ? 0 : (t == 1) ? TIMEOUT : (t == 2) ? TIMEOUT + 1 : 1, 0);
    end

    // Long response stall with competing requests, then hand-off.
    rand_cmds();
    run_txn(4'b1111, 1, 10);
    rand_cmds();
    run_txn(4'b1111, 1, 0);

    // Reset while waiting on the ALU.
    rand_cmds();
    stub_lat  = 0;
    req_valid = 4'b0100;
    #1;
    chk("rstwait_accept", 32'(req_ready), 32'(4'b0100));
    @(negedge clock);
    @(negedge clock);
    chk("rstwait_busy", 32'(busy), 1);
    req_valid = 4'b1111;
    reset     = 1'b1;
    #1;
    chk("rstwait_reset_ready", 32'(req_ready), 0);
    chk("rstwait_reset_rsp", 32'(rsp_valid), 0);
    @(negedge clock);
    chk_reset_outputs();
    reset  = 1'b0;
    last_g = NREQ - 1;
    rand_cmds();
    run_txn(4'b0101, 1, 0);

    // Randomized traffic.
    for (int t = 0; t < 20; t++) begin
      rand_cmds();
      run_txn(NREQ'($urandom_range(1, 15)), lat_tab[$urandom_range(0, 7)], int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
